elastic_fifo: RTL and testbench
===============================

# elastic_fifo

Parametrised elastic buffer for the valid/ready streaming fabric. It generalises the single-entry elastic stage to `depth_p` entries and adds occupancy and almost-full reporting. Its `ready_o` depends only on internal state, so it breaks the combinational ready path between producer and consumer. It sits between pipeline stages in the vision datapath, for example between the camera capture stage and the filter stages, to absorb burst and backpressure mismatch.

## Interface
- `width_p`, 8: payload width in bits.
- `depth_p`, 4: number of entries. Must be a power of two and at least 2.
- `almost_full_p`, `depth_p-1`: occupancy at or above which `almost_full_o` asserts. Range 1..`depth_p`.
- `datapath_reset_p`, 0: when 1, reset clears all storage entries to 0. When 0, storage is not reset.

- `clk_i` input 1: clock. All state changes on the rising edge.
- `reset_ni` input 1: reset, asynchronous and active-low.
- `data_i` input `width_p`: upstream payload.
- `valid_i` input 1: upstream valid.
- `ready_o` output 1: buffer can accept a word.
- `valid_o` output 1: `data_o` holds a valid word.
- `data_o` output `width_p`: head-of-queue payload.
- `ready_i` input 1: downstream ready.
- `count_o` output `$clog2(depth_p)+1`: current occupancy, 0..`depth_p`.
- `almost_full_o` output 1: `count_o >= almost_full_p`.

## Operation
- Storage is a circular array indexed by `wr_ptr_r` and `rd_ptr_r`. Each pointer is `$clog2(depth_p)+1` bits; the MSB is the wrap bit.
- Empty: pointers are equal. Full: index bits are equal and wrap bits differ.
- `count_o = wr_ptr_r - rd_ptr_r`, computed modulo 2^(`$clog2(depth_p)+1`).
- Enqueue when `valid_i && ready_o`: write `data_i` at `wr_ptr_r` and increment `wr_ptr_r`.
- Dequeue when `valid_o && ready_i`: increment `rd_ptr_r`.
- `ready_o = !full` while `reset_ni` is high, and 0 while `reset_ni` is low. `ready_o` never depends on `ready_i`.
- `valid_o = !empty`. `data_o = mem[rd_ptr_r index]`. When empty, `data_o` is the stale entry and carries no meaning.
- Simultaneous enqueue and dequeue when partially full: both pointers advance and `count_o` is unchanged.
- When full, `ready_o` is 0 even if `ready_i` is 1. There is no pass-through into a full buffer.
- When empty, only an enqueue can occur.
- Both pointers wrap naturally from `depth_p-1` to 0 and toggle the wrap bit. No special-case logic is needed.
- Words leave in strict arrival order. No word is lost or duplicated.
- `valid_o` must stay asserted, and `data_o` must stay stable, while `ready_i` is low. This is the standard hold rule.
- The upstream holding rule is the producer's responsibility. The buffer does not check it.

## Timing
- Reset asserted (`reset_ni` low, asynchronous):
  - pointers become 0.
  - `valid_o`, `ready_o`, `count_o`, and `almost_full_o` are all 0.
  - storage is cleared only if `datapath_reset_p` is 1.
- First rising edge after reset is released: `ready_o` is 1.
- Reset asserted in the middle of operation: all queued words are discarded immediately, without waiting for a clock edge.
- Latency, with bypass compiled out: a word accepted at edge N appears on `valid_o`/`data_o` after edge N. That is 1 cycle.
- Throughput: 1 word per cycle sustained when `ready_i` is held high, at any occupancy below full.
- `count_o` and `almost_full_o` are registered-derived. They reflect the edge just past, not the current cycle's handshakes.
- Combinational paths:
  - `ready_o` has none.
  - `valid_o`, `data_o`, and `count_o` depend only on state, unless bypass is enabled.

## Configuration
- Macro: `ELASTIC_FIFO_BYPASS_EN`.
- Defined: when the buffer is empty and `valid_i` is 1, then `valid_o` is 1 and `data_o = data_i` in the same cycle.
  - If `ready_i` is also 1, the word passes straight through. It is not written, and the pointers and count do not change.
  - If `ready_i` is 0, the word is enqueued normally.
  - This gives zero-latency pass-through but adds a combinational path from `valid_i`/`data_i` to `valid_o`/`data_o`.
- Undefined: there are no combinational input-to-output paths, and minimum latency is 1 cycle.
- `ready_o` behaviour is identical in both builds.

## Test plan
- Reset and fill: hold `reset_ni` low for 2 cycles, then push 0x11, 0x22, 0x33, 0x44 with `ready_i`=0 (`depth_p`=4).
  - Expected: `count_o` goes 1, 2, 3, 4.
  - `almost_full_o` asserts at count 3.
  - `ready_o` drops after the 4th accept.
  - A 5th push of 0x55 is not accepted.
- Drain order: from the full state, set `ready_i`=1.
  - Expected: `data_o` is 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then `valid_o`=0 and `count_o`=0.
- Streaming with wrap: hold `valid_i` and `ready_i` high for 20 cycles with an incrementing payload 0x00..0x13.
  - Expected: every value is observed once, in order, with `count_o` held steady at 1 after the first cycle.
  - With bypass enabled, `count_o` instead stays at 0.
- Random backpressure: drive 1000 words with random `valid_i` and `ready_i`.
  - Expected: the scoreboard matches order, no drops, and `count_o` equals (accepted − delivered) every cycle.
- Asynchronous reset mid-stream: with `count_o`=3, pull `reset_ni` low between clock edges.
  - Expected: `valid_o`=0 and `count_o`=0 before the next edge.
  - After release, the next push of 0xA5 is the first word out.
- Bypass build: with the buffer empty, `valid_i`=1, `data_i`=0x5A, and `ready_i`=1.
  - Expected: `valid_o`=1 and `data_o`=0x5A in the same cycle, with `count_o` remaining 0.

Source files
------------

// File: rtl/elastic_fifo.sv
// Parametrised valid/ready elastic buffer with occupancy and almost-full reporting.
// Optional zero-latency pass-through when empty: define ELASTIC_FIFO_BYPASS_EN.
module elastic_fifo #(
   parameter int unsigned width_p          = 8,
   parameter int unsigned depth_p          = 4,
   parameter int unsigned almost_full_p    = depth_p - 1,
   parameter bit          datapath_reset_p = 1'b0
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic [width_p-1:0]         data_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic                       valid_o,
   output logic [width_p-1:0]         data_o,
   input  logic                       ready_i,
   output logic [$clog2(depth_p):0]   count_o,
   output logic                       almost_full_o
);

   localparam int unsigned addr_w = $clog2(depth_p);
   localparam int unsigned ptr_w  = addr_w + 1;

   logic [width_p-1:0] mem [depth_p];
   logic [ptr_w-1:0]   wr_ptr_r;
   logic [ptr_w-1:0]   rd_ptr_r;
   logic [addr_w-1:0]  wr_idx;
   logic [addr_w-1:0]  rd_idx;
   logic               empty;
   logic               full;
   logic               push;
   logic               wr_en;
   logic               pop;

   assign wr_idx = wr_ptr_r[addr_w-1:0];
   assign rd_idx = rd_ptr_r[addr_w-1:0];

   // Wrap bit distinguishes full from empty when the index bits match
   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_idx == rd_idx) && (wr_ptr_r[ptr_w-1] != rd_ptr_r[ptr_w-1]);

   assign ready_o       = reset_ni & ~full;
   assign count_o       = wr_ptr_r - rd_ptr_r;
   assign almost_full_o = (count_o >= ptr_w'(almost_full_p));
   assign push          = valid_i & ready_o;
   assign pop           = ~empty & ready_i;

`ifdef ELASTIC_FIFO_BYPASS_EN
   logic bypass;

   // An empty buffer presents the incoming word directly; it is stored only if not taken
   assign bypass  = empty & valid_i & reset_ni;
   assign valid_o = ~empty | bypass;
   assign data_o  = empty ? data_i : mem[rd_idx];
   assign wr_en   = push & ~(bypass & ready_i);
`else
   assign valid_o = ~empty;
   assign data_o  = mem[rd_idx];
   assign wr_en   = push;
`endif

   // Pointer update
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_r <= wr_ptr_r + ptr_w'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + ptr_w'(1);
         end
      end
   end

   // Storage, optionally cleared by reset
   if (datapath_reset_p) begin : g_mem_rst
      always_ff @(posedge clk_i or negedge reset_ni) begin
         if (!reset_ni) begin
            for (int i = 0; i < int'(depth_p); i++) begin
               mem[i] <= '0;
            end
         end else if (wr_en) begin
            mem[wr_idx] <= data_i;
         end
      end
   end else begin : g_mem_norst
      always_ff @(posedge clk_i) begin
         if (wr_en) begin
            mem[wr_idx] <= data_i;
         end
      end
   end

endmodule

// File: tb/tb_elastic_fifo.sv
// Self-checking bench for elastic_fifo: scoreboard queue model checked every cycle.
// Follows the DUT build: define ELASTIC_FIFO_BYPASS_EN for both to test pass-through.
module tb_elastic_fifo;

   localparam int unsigned W = 8;
   localparam int unsigned D = 4;
   localparam int unsigned AF = D - 1;

   logic                clk_i;
   logic                reset_ni;
   logic [W-1:0]        data_i;
   logic                valid_i;
   logic                ready_o;
   logic                valid_o;
   logic [W-1:0]        data_o;
   logic                ready_i;
   logic [$clog2(D):0]  count_o;
   logic                almost_full_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [W-1:0] sb [$];
   bit          acc_last;

   elastic_fifo #(
      .width_p(W),
      .depth_p(D),
      .almost_full_p(AF),
      .datapath_reset_p(1'b0)
   ) dut (
      .clk_i(clk_i),
      .reset_ni(reset_ni),
      .data_i(data_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .valid_o(valid_o),
      .data_o(data_o),
      .ready_i(ready_i),
      .count_o(count_o),
      .almost_full_o(almost_full_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: compare outputs with the model at negedge, update the model, return #1 after posedge
   task automatic cycle();
      int          n;
      logic        exp_valid;
      logic        exp_ready;
      logic [W-1:0] exp_data;
      bit          pass;
      @(negedge clk_i);
      n         = sb.size();
      exp_ready = reset_ni && (n < int'(D));
      exp_valid = (n > 0);
      exp_data  = (n > 0) ? sb[0] : '0;
      pass      = 1'b0;
`ifdef ELASTIC_FIFO_BYPASS_EN
      if (n == 0 && valid_i && reset_ni) begin
         exp_valid = 1'b1;
         exp_data  = data_i;
         pass      = ready_i;
      end
`endif
      check("ready", 32'(ready_o), 32'(exp_ready));
      check("valid", 32'(valid_o), 32'(exp_valid));
      check("count", 32'(count_o), 32'(n));
      check("almost_full", 32'(almost_full_o), 32'(n >= int'(AF)));
      if (exp_valid) check("data", 32'(data_o), 32'(exp_data));
      acc_last = valid_i && exp_ready;
      if (n > 0 && ready_i) void'(sb.pop_front());
      if (acc_last && !pass) sb.push_back(data_i);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] fill_vals [4];
      int           sent;
      bit           pending;

      fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      reset_ni = 1'b0;
      valid_i  = 1'b0;
      ready_i  = 1'b0;
      data_i   = '0;
      @(posedge clk_i);
      #1;

      // Reset held for two cycles
      cycle();
      cycle();
      reset_ni = 1'b1;

      // Fill to full with no downstream ready, then attempt a fifth push
      foreach (fill_vals[i]) begin
         valid_i = 1'b1;
         data_i  = fill_vals[i];
         cycle();
      end
      data_i = 8'h55;
      cycle();
      cycle();

      // Drain in order
      valid_i = 1'b0;
      ready_i = 1'b1;
      repeat (4) cycle();
      cycle();

      // Streaming through the wrap point
      for (int i = 0; i < 20; i++) begin
         valid_i = 1'b1;
         data_i  = W'(i);
         cycle();
      end
      valid_i = 1'b0;
      for (int k = 0; k < 8 && sb.size() > 0; k++) cycle();
      cycle();

      // Random valid/backpressure with producer holding its word until accepted
      sent    = 0;
      pending = 1'b0;
      for (int c = 0; c < 20000 && sent < 1000; c++) begin
         if (!pending && $urandom_range(0, 3) != 0) begin
            pending = 1'b1;
            data_i  = W'($urandom);
         end
         valid_i = pending;
         ready_i = ($urandom_range(0, 2) != 0);
         cycle();
         if (acc_last) begin
            pending = 1'b0;
            sent++;
         end
      end
      check("random_sent", 32'(sent), 32'd1000);
      valid_i = 1'b0;
      ready_i = 1'b1;
      for (int k = 0; k < 10 && sb.size() > 0; k++) cycle();
      cycle();

      // Asynchronous reset with three words queued
      ready_i = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         valid_i = 1'b1;
         data_i  = W'(i);
         cycle();
      end
      valid_i = 1'b0;
      check("pre_reset_count", 32'(count_o), 32'd3);
      #2;
      reset_ni = 1'b0;
      #1;
      check("async_valid", 32'(valid_o), 32'd0);
      check("async_count", 32'(count_o), 32'd0);
      check("async_ready", 32'(ready_o), 32'd0);
      check("async_almost_full", 32'(almost_full_o), 32'd0);
      sb.delete();
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      valid_i  = 1'b1;
      data_i   = 8'hA5;
      cycle();
      valid_i = 1'b0;
      ready_i = 1'b1;
      check("first_after_reset", 32'(data_o), 32'hA5);
      cycle();
      cycle();

`ifdef ELASTIC_FIFO_BYPASS_EN
      // Same-cycle pass-through when empty
      valid_i = 1'b1;
      data_i  = 8'h5A;
      ready_i = 1'b1;
      #1;
      check("bypass_valid", 32'(valid_o), 32'd1);
      check("bypass_data", 32'(data_o), 32'h5A);
      check("bypass_count", 32'(count_o), 32'd0);
      cycle();
      valid_i = 1'b0;
      cycle();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
